// File: rtl/datapath_run_ctrl_if.sv
// Command channel between the debug host and the run controller.
// The host drives the master side and the controller implements the slave side.
interface datapath_run_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;

  modport master (output cmd_valid, output cmd_op, output cmd_count, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_count, output cmd_ready);
endinterface

// File: rtl/datapath_run_ctrl.sv
// Run/step sequencer that gates a single-cycle MIPS datapath with a per-cycle enable.
// Optional breakpoint support is enabled with the RUN_CTRL_BRKPT_EN macro.
module datapath_run_ctrl #(
  parameter int          CNT_W       = 16,
  parameter int          INIT_CYCLES = 2,
  parameter logic [31:0] HALT_WORD   = 32'h0000000C
) (
  input  logic                clk,
  input  logic                rst,
  datapath_run_ctrl_if.slave  cmd,
  input  logic [31:0]         pc,
  input  logic [31:0]         instruction,
`ifdef RUN_CTRL_BRKPT_EN
  input  logic                bp_valid,
  input  logic [31:0]         bp_addr,
`endif
  output logic                dp_rst_n,
  output logic                dp_en,
  output logic                busy,
  output logic                done,
  output logic                cmd_err,
  output logic [1:0]          stop_cause,
  output logic [31:0]         instr_count
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RUN, S_COUNT} state_t;

  localparam logic [1:0] OP_HALT  = 2'b00;
  localparam logic [1:0] OP_STEP  = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_RUN_N = 2'b11;

  localparam logic [1:0] CAUSE_COUNT = 2'd0;
  localparam logic [1:0] CAUSE_HALT  = 2'd1;
  localparam logic [1:0] CAUSE_HWORD = 2'd2;
  localparam logic [1:0] CAUSE_BRKPT = 2'd3;

  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  state_t           state_reg;
  logic [IW-1:0]    init_cnt_reg;
  logic [CNT_W-1:0] remaining_reg;
  logic             dp_rst_n_reg;
  logic             done_reg;
  logic             cmd_err_reg;
  logic [1:0]       stop_cause_reg;
  logic [31:0]      instr_count_reg;

  logic busy_w;
  logic cmd_fire;
  logic halt_cmd;
  logic halt_word;
  logic bp_hit;

  assign busy_w        = (state_reg == S_RUN) || (state_reg == S_COUNT);
  assign cmd.cmd_ready = (state_reg != S_INIT);
  assign cmd_fire      = cmd.cmd_valid && (state_reg != S_INIT);
  assign halt_cmd      = cmd_fire && (cmd.cmd_op == OP_HALT);
  assign halt_word     = (instruction == HALT_WORD);

`ifdef RUN_CTRL_BRKPT_EN
  // Set on every idle cycle so the first busy cycle after an accept steps past the breakpoint.
  logic bp_skip_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_skip_reg <= 1'b0;
    end else begin
      bp_skip_reg <= (state_reg == S_IDLE);
    end
  end

  assign bp_hit = bp_valid && busy_w && (pc == bp_addr) && !bp_skip_reg;
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  assign bp_hit    = 1'b0;
`endif

  assign dp_en = busy_w && !halt_word && !bp_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_INIT;
      init_cnt_reg    <= '0;
      remaining_reg   <= '0;
      dp_rst_n_reg    <= 1'b0;
      done_reg        <= 1'b0;
      cmd_err_reg     <= 1'b0;
      stop_cause_reg  <= CAUSE_COUNT;
      instr_count_reg <= '0;
    end else begin
      done_reg    <= 1'b0;
      cmd_err_reg <= 1'b0;
      if (dp_en) begin
        instr_count_reg <= instr_count_reg + 32'd1;
      end
      case (state_reg)
        S_INIT: begin
          if (init_cnt_reg == IW'(INIT_CYCLES - 1)) begin
            state_reg    <= S_IDLE;
            dp_rst_n_reg <= 1'b1;
          end else begin
            init_cnt_reg <= init_cnt_reg + 1'b1;
          end
        end
        S_IDLE: begin
          if (cmd_fire) begin
            case (cmd.cmd_op)
              OP_HALT: done_reg <= 1'b1;
              OP_STEP: begin
                remaining_reg <= CNT_W'(1);
                state_reg     <= S_COUNT;
              end
              OP_RUN: state_reg <= S_RUN;
              OP_RUN_N: begin
                if (cmd.cmd_count == '0) begin
                  done_reg       <= 1'b1;
                  stop_cause_reg <= CAUSE_COUNT;
                end else begin
                  remaining_reg <= cmd.cmd_count;
                  state_reg     <= S_COUNT;
                end
              end
              default: ;
            endcase
          end
        end
        default: begin
          // Non-HALT commands are dropped while busy; they only raise cmd_err.
          if (cmd_fire && (cmd.cmd_op != OP_HALT)) begin
            cmd_err_reg <= 1'b1;
          end
          if (dp_en) begin
            remaining_reg <= remaining_reg - 1'b1;
          end
          if (halt_cmd) begin
            state_reg      <= S_IDLE;
            done_reg       <= 1'b1;
            stop_cause_reg <= CAUSE_HALT;
          end else if (halt_word) begin
            state_reg      <= S_IDLE;
            done_reg       <= 1'b1;
            stop_cause_reg <= CAUSE_HWORD;
          end else if (bp_hit) begin
            state_reg      <= S_IDLE;
            done_reg       <= 1'b1;
            stop_cause_reg <= CAUSE_BRKPT;
          end else if ((state_reg == S_COUNT) && dp_en && (remaining_reg == CNT_W'(1))) begin
            state_reg      <= S_IDLE;
            done_reg       <= 1'b1;
            stop_cause_reg <= CAUSE_COUNT;
          end
        end
      endcase
    end
  end

  assign dp_rst_n    = dp_rst_n_reg;
  assign busy        = busy_w;
  assign done        = done_reg;
  assign cmd_err     = cmd_err_reg;
  assign stop_cause  = stop_cause_reg;
  assign instr_count = instr_count_reg;

endmodule

// File: tb/tb_datapath_run_ctrl.sv
// Self-checking bench for datapath_run_ctrl: directed scenarios then random commands,
// every cycle compared against an integer-level model of the run/step rules.
module tb_datapath_run_ctrl;
  localparam int          CNT_W       = 16;
  localparam int          INIT_CYCLES = 2;
  localparam logic [31:0] HALT_WORD   = 32'h0000000C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'd0;
  logic [31:0] instruction = 32'd0;
  logic        dp_rst_n, dp_en, busy, done, cmd_err;
  logic [1:0]  stop_cause;
  logic [31:0] instr_count;
`ifdef RUN_CTRL_BRKPT_EN
  logic        bp_valid = 1'b0;
  logic [31:0] bp_addr = 32'd0;
`endif

  int checks = 0;
  int failures = 0;
  int en_seen = 0;

  // Model state: busy flag, instructions left (-1 = free run), init edges left.
  int          m_init;
  bit          m_busy, m_done, m_err, m_skip;
  int          m_rem;
  int          m_cause;
  bit [31:0]   m_cnt;

  always #5 clk = ~clk;

  datapath_run_ctrl_if #(.CNT_W(CNT_W)) cmd_if ();

  datapath_run_ctrl #(.CNT_W(CNT_W), .INIT_CYCLES(INIT_CYCLES), .HALT_WORD(HALT_WORD)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if.slave), .pc(pc), .instruction(instruction),
`ifdef RUN_CTRL_BRKPT_EN
    .bp_valid(bp_valid), .bp_addr(bp_addr),
`endif
    .dp_rst_n(dp_rst_n), .dp_en(dp_en), .busy(busy), .done(done), .cmd_err(cmd_err),
    .stop_cause(stop_cause), .instr_count(instr_count)
  );

  // Minimal datapath stand-in: PC advances by one word per retired instruction.
  always @(posedge clk) begin
    if (!dp_rst_n) pc <= 32'd0;
    else if (dp_en) pc <= pc + 32'd4;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_init = INIT_CYCLES; m_busy = 0; m_done = 0; m_err = 0; m_skip = 0;
    m_rem = 0; m_cause = 0; m_cnt = '0;
  endtask

  task automatic send(input logic [1:0] op, input int cnt);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_count = CNT_W'(cnt);
  endtask

  task automatic stop(input int cause);
    m_busy = 0; m_done = 1; m_cause = cause;
  endtask

  // Check the current cycle against the model, then advance one clock.
  task automatic cyc();
    bit en, bp, fire, was_busy;
    #1;
    bp = 0;
`ifdef RUN_CTRL_BRKPT_EN
    bp = bp_valid && m_busy && (pc == bp_addr) && !m_skip;
`endif
    en = m_busy && (instruction != HALT_WORD) && !bp;
    chk("dp_en", dp_en, en);
    chk("busy", busy, m_busy);
    chk("cmd_ready", cmd_if.cmd_ready, m_init == 0);
    chk("dp_rst_n", dp_rst_n, m_init == 0);
    chk("done", done, m_done);
    chk("cmd_err", cmd_err, m_err);
    chk("stop_cause", stop_cause, m_cause);
    chk("instr_count", instr_count, m_cnt);
    en_seen += int'(dp_en);

    fire = cmd_if.cmd_valid && (m_init == 0);
    if (fire)
      $display("t=%0t cmd op=%0d count=%0d busy=%0b pc=%0h", $time, cmd_if.cmd_op,
               cmd_if.cmd_count, m_busy, pc);
    was_busy = m_busy;
    m_done = 0; m_err = 0;
    if (m_init > 0) begin
      m_init--;
    end else if (!m_busy) begin
      if (fire) begin
        case (cmd_if.cmd_op)
          2'd0: m_done = 1;
          2'd1: begin m_busy = 1; m_rem = 1; end
          2'd2: begin m_busy = 1; m_rem = -1; end
          default: begin
            if (cmd_if.cmd_count == 0) begin m_done = 1; m_cause = 0; end
            else begin m_busy = 1; m_rem = int'(cmd_if.cmd_count); end
          end
        endcase
      end
    end else begin
      if (en) m_cnt = m_cnt + 1;
      if (fire && cmd_if.cmd_op != 2'd0) m_err = 1;
      if (fire && cmd_if.cmd_op == 2'd0) stop(1);
      else if (instruction == HALT_WORD) stop(2);
      else if (bp) stop(3);
      else if (m_rem > 0 && en) begin
        m_rem--;
        if (m_rem == 0) stop(0);
      end
    end
    m_skip = !was_busy;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic run_until_done(input int max_cyc, output int n);
    n = 0;
    while (n < max_cyc && !done) begin
      cyc();
      n++;
    end
    chk("done_within_budget", done, 1'b1);
  endtask

  initial begin
    int n;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'd0;
    cmd_if.cmd_count = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dp_rst_n", dp_rst_n, 1'b0);
    chk("rst_cmd_ready", cmd_if.cmd_ready, 1'b0);
    chk("rst_dp_en", dp_en, 1'b0);
    chk("rst_instr_count", instr_count, 32'd0);

    // 1: release reset, count cycles of dp_rst_n low
    rst = 1'b0;
    n = 0;
    while (n < 10 && !dp_rst_n) begin cyc(); n++; end
    chk("t1_init_cycles", n, 2);
    cyc();

    // 2: RUN_N 5
    en_seen = 0;
    send(2'd3, 5);
    run_until_done(20, n);
    chk("t2_latency", n, 6);
    chk("t2_en_cycles", en_seen, 5);
    chk("t2_instr_count", instr_count, 32'd5);
    chk("t2_cause", stop_cause, 32'd0);
    cyc();

    // 3: RUN, STEP while busy, HALT 10 cycles later
    send(2'd2, 0);
    cyc();
    en_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) send(2'd1, 0);
      cyc();
      if (i == 4) chk("t3_cmd_err", cmd_err, 1'b1);
    end
    chk("t3_still_busy", busy, 1'b1);
    send(2'd0, 0);
    cyc();
    chk("t3_en_cycles", en_seen, 11);
    chk("t3_cause", stop_cause, 32'd1);
    chk("t3_done", done, 1'b1);
    chk("t3_instr_count", instr_count, 32'd16);
    cyc();

    // 4: HALT_WORD on the 4th busy cycle, then HALT_WORD together with HALT cmd
    send(2'd2, 0);
    cyc();
    en_seen = 0;
    repeat (3) cyc();
    instruction = HALT_WORD;
    cyc();
    instruction = 32'd0;
    chk("t4_en_cycles", en_seen, 3);
    chk("t4_cause", stop_cause, 32'd2);
    chk("t4_instr_count", instr_count, 32'd19);
    send(2'd2, 0);
    cyc();
    instruction = HALT_WORD;
    send(2'd0, 0);
    cyc();
    instruction = 32'd0;
    chk("t4_halt_priority", stop_cause, 32'd1);
    cyc();

    // 5: reset in the middle of RUN_N 100, then RUN_N 0
    send(2'd3, 100);
    cyc();
    repeat (7) cyc();
    rst = 1'b1;
    model_reset();
    #1;
    chk("t5_dp_en_in_rst", dp_en, 1'b0);
    chk("t5_count_cleared", instr_count, 32'd0);
    chk("t5_dp_rst_n", dp_rst_n, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    while (n < 10 && !dp_rst_n) begin cyc(); n++; end
    chk("t5_reinit_cycles", n, 2);
    en_seen = 0;
    send(2'd3, 0);
    cyc();
    chk("t5_zero_done", done, 1'b1);
    cyc();
    chk("t5_zero_en", en_seen, 0);

`ifdef RUN_CTRL_BRKPT_EN
    // 6: breakpoint at 0x10, then step past it
    bp_valid = 1'b1;
    bp_addr  = 32'h10;
    send(2'd2, 0);
    run_until_done(20, n);
    chk("t6_bp_pc", pc, 32'h10);
    chk("t6_bp_cause", stop_cause, 32'd3);
    send(2'd1, 0);
    run_until_done(10, n);
    chk("t6_step_pc", pc, 32'h14);
    chk("t6_step_cause", stop_cause, 32'd0);
    bp_valid = 1'b0;
`endif

    // Random commands and instruction stream against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) send(2'($urandom_range(3)), int'($urandom_range(5)));
      instruction = ($urandom_range(9) == 0) ? HALT_WORD : $urandom;
`ifdef RUN_CTRL_BRKPT_EN
      bp_valid = ($urandom_range(3) == 0);
      bp_addr  = pc + 32'(4 * $urandom_range(2));
`endif
      cyc();
    end
    instruction = 32'd0;
    send(2'd0, 0);
    cyc();
    cyc();
    chk("final_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
